// File: rtl/primus_pkg.sv
// Shared types and constants for the primus instruction-memory responder.
package primus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned WAIT_CNT_W = 4;

  // A fetch faults when the PC is not word aligned or lies beyond the stored words.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth));
  endfunction

endpackage

// File: rtl/primus_imem_array.sv
// Word storage: one synchronous write port and one registered read port, no reset.
module primus_imem_array #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Non-blocking read and write on the same edge give read-before-write ordering.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/primus_imem_responder.sv
// Instruction fetch responder: single outstanding request, fixed wait states,
// fault detection for misaligned or out-of-range PCs.
module primus_imem_responder
  import primus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [31:0] rsp_pc_o,
  output logic        rsp_err_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  imem_state_e           state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  ready_q;
  logic [31:0]           pc_q;
  logic                  err_q;
  logic [31:0]           rd_data;
  logic                  accept;
  logic                  req_fault;
  logic                  wr_hit;
  logic                  unused_wr_lsb;

  assign accept        = req_valid_i & ready_q;
  assign req_fault     = addr_fault(req_addr_i, DEPTH_WORDS);
  assign wr_hit        = wr_en_i && (wr_addr_i[31:2] < 30'(DEPTH_WORDS));
  assign unused_wr_lsb = ^wr_addr_i[1:0];

  primus_imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk_i),
    .wr_en   (wr_hit),
    .wr_idx  (wr_addr_i[AW+1:2]),
    .wr_data (wr_data_i),
    .rd_en   (accept),
    .rd_idx  (req_addr_i[AW+1:2]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP: begin
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ready is registered from the next state so it stays low through reset
  // and rises on the first edge after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= (state_nxt == IDLE);
      if (accept) begin
        pc_q  <= req_addr_i;
        err_q <= req_fault;
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = (state == RESP);
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_pc_o    = rsp_valid_o ? pc_q : '0;
  assign rsp_data_o  = !rsp_valid_o ? '0 : (err_q ? NOP_INSTR : rd_data);

endmodule

// File: tb/tb_primus_imem_responder.sv
// Directed and random bench: instance 0 runs with no wait states, instance 1 with one.
module tb_primus_imem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic [31:0] rsp_pc    [2];
  logic        rsp_err   [2];
  logic        wr_en     [2];
  logic [31:0] wr_addr   [2];
  logic [31:0] wr_data   [2];

  logic [31:0] model [2][DEPTH];
  exp_t        sbq [$];
  int unsigned lat [2] = '{1, 2};
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  primus_imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_data_o(rsp_data[0]),
    .rsp_pc_o(rsp_pc[0]), .rsp_err_o(rsp_err[0]),
    .wr_en_i(wr_en[0]), .wr_addr_i(wr_addr[0]), .wr_data_i(wr_data[0])
  );

  primus_imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_data_o(rsp_data[1]),
    .rsp_pc_o(rsp_pc[1]), .rsp_err_o(rsp_err[1]),
    .wr_en_i(wr_en[1]), .wr_addr_i(wr_addr[1]), .wr_data_i(wr_data[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] addr);
    return addr[31:2] < 30'(DEPTH);
  endfunction

  task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data);
    wr_en[d] = 1'b1; wr_addr[d] = addr; wr_data[d] = data;
    if (in_range(addr)) model[d][addr[31:2]] = data;
    @(negedge clk);
    wr_en[d] = 1'b0;
  endtask

  // Issue one request, check latency, response fields, hold under backpressure
  // and the return to idle. Optional write to the same word in the accept
  // cycle (same_wr) or during the held response (late_wr).
  task automatic do_req(input int d, input logic [31:0] addr, input int unsigned hold,
                        input bit same_wr, input logic [31:0] same_data, input bit late_wr);
    exp_t e;
    int   n;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'b0, req_ready[d]}, 32'd1);
    e.pc   = addr;
    e.err  = (addr[1:0] != 2'b00) || !in_range(addr);
    e.data = e.err ? NOP : model[d][addr[31:2]];
    sbq.push_back(e);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    if (same_wr) begin
      wr_en[d] = 1'b1; wr_addr[d] = addr; wr_data[d] = same_data;
      if (in_range(addr)) model[d][addr[31:2]] = same_data;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = '0;
    wr_en[d]     = 1'b0;
    for (int unsigned k = 1; k < lat[d]; k++) begin
      chk("valid_early", {31'b0, rsp_valid[d]}, 32'd0);
      chk("ready_in_wait", {31'b0, req_ready[d]}, 32'd0);
      @(negedge clk);
    end
    chk("valid_at_latency", {31'b0, rsp_valid[d]}, 32'd1);
    e = sbq.pop_front();
    chk("rsp_data", rsp_data[d], e.data);
    chk("rsp_pc", rsp_pc[d], e.pc);
    chk("rsp_err", {31'b0, rsp_err[d]}, {31'b0, e.err});
    for (int unsigned h = 0; h < hold; h++) begin
      if (late_wr && h == 0) begin
        wr_en[d] = 1'b1; wr_addr[d] = addr; wr_data[d] = ~e.data;
        if (in_range(addr)) model[d][addr[31:2]] = ~e.data;
      end
      @(negedge clk);
      wr_en[d] = 1'b0;
      chk("hold_valid", {31'b0, rsp_valid[d]}, 32'd1);
      chk("hold_data", rsp_data[d], e.data);
      chk("hold_pc", rsp_pc[d], e.pc);
      chk("hold_err", {31'b0, rsp_err[d]}, {31'b0, e.err});
      chk("hold_ready", {31'b0, req_ready[d]}, 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("idle_valid", {31'b0, rsp_valid[d]}, 32'd0);
    chk("idle_ready", {31'b0, req_ready[d]}, 32'd1);
    chk("idle_data", rsp_data[d], 32'd0);
    chk("idle_pc", rsp_pc[d], 32'd0);
    chk("idle_err", {31'b0, rsp_err[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b0;
      wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", {31'b0, req_ready[i]}, 32'd0);
      chk("rst_valid", {31'b0, rsp_valid[i]}, 32'd0);
      chk("rst_data", rsp_data[i], 32'd0);
      chk("rst_pc", rsp_pc[i], 32'd0);
      chk("rst_err", {31'b0, rsp_err[i]}, 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    #1;
    chk("ready_before_edge", {31'b0, req_ready[1]}, 32'd0);
    @(negedge clk);
    chk("ready_after_edge0", {31'b0, req_ready[0]}, 32'd1);
    chk("ready_after_edge1", {31'b0, req_ready[1]}, 32'd1);

    // One wait state: basic fetch, backpressure with a late write, faults.
    do_write(1, 32'h8, 32'h0050_0093);
    do_req(1, 32'h8, 0, 1'b0, '0, 1'b0);
    do_write(1, 32'hC, 32'h1234_5678);
    do_req(1, 32'hC, 5, 1'b0, '0, 1'b1);
    do_req(1, 32'hC, 0, 1'b0, '0, 1'b0);
    do_req(1, 32'h6, 0, 1'b0, '0, 1'b0);
    do_req(1, 4 * DEPTH, 0, 1'b0, '0, 1'b0);
    do_write(1, 32'hFC, 32'hCAFE_F00D);
    do_req(1, 32'hFC, 0, 1'b0, '0, 1'b0);
    do_req(1, 32'hFFFF_FFFC, 0, 1'b0, '0, 1'b0);
    do_write(1, 32'h10, 32'h1111_1111);
    do_req(1, 32'h10, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_req(1, 32'h10, 0, 1'b0, '0, 1'b0);
    do_write(1, 4 * DEPTH + 32'h8, 32'hBAD0_BAD0);
    do_req(1, 32'h8, 0, 1'b0, '0, 1'b0);

    // Reset pulse while the request sits in WAIT: it must vanish.
    req_valid[1] = 1'b1; req_addr[1] = 32'h8;
    @(negedge clk);
    req_valid[1] = 1'b0; req_addr[1] = '0;
    rst_n[1] = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, req_ready[1]}, 32'd0);
    chk("midrst_valid", {31'b0, rsp_valid[1]}, 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    chk("midrst_ready_release", {31'b0, req_ready[1]}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", {31'b0, rsp_valid[1]}, 32'd0);
      if (i == 0) chk("midrst_ready_edge", {31'b0, req_ready[1]}, 32'd1);
    end
    do_req(1, 32'h8, 0, 1'b0, '0, 1'b0);

    // No wait states: fill memory, then directed and random fetches.
    for (int i = 0; i < int'(DEPTH); i++) do_write(0, 32'(i * 4), $urandom);
    do_req(0, 32'h0, 0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      a = 32'($urandom_range(DEPTH - 1, 0)) << 2;
      do_req(0, a, $urandom_range(2, 0), 1'b0, '0, 1'b0);
    end
    do_req(0, 32'h2, 1, 1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
